// File: rtl/multi_ch_photon_binner_pkg.sv
// Shared definitions for the multi-channel photon binner: output word layout,
// reset constants and the serialiser state type.
package photon_cnt_pkg;

  // Bit positions of the fields inside one 64-bit output word.
  localparam int TRIG_B  = 63;
  localparam int SAT_B   = 62;
  localparam int CH_MSB  = 61;
  localparam int CH_LSB  = 56;
  localparam int CNT_MSB = 55;
  localparam int CNT_LSB = 32;
  localparam int SEQ_MSB = 31;
  localparam int SEQ_LSB = 0;

  // Bin length loaded into both the active and pending registers on reset.
  localparam logic [15:0] TAO_RESET = 16'hFFFF;

  // Serialiser: either waiting for a snapshot or streaming its words.
  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  // Assemble one output word from its fields; the count is already zero-extended.
  function automatic logic [63:0] pack_word(input logic        trig,
                                            input logic        sat,
                                            input logic [5:0]  ch,
                                            input logic [23:0] cnt,
                                            input logic [31:0] seq);
    logic [63:0] w;
    w = '0;
    w[TRIG_B]          = trig;
    w[SAT_B]           = sat;
    w[CH_MSB:CH_LSB]   = ch;
    w[CNT_MSB:CNT_LSB] = cnt;
    w[SEQ_MSB:SEQ_LSB] = seq;
    return w;
  endfunction

endpackage

// File: rtl/multi_ch_photon_binner_pho_edge_sync.sv
// Synchroniser for one asynchronous input followed by a rising-edge detector.
// The output is a single-cycle pulse for every 0->1 transition of the
// synchronised level; reset empties the whole chain.
module pho_edge_sync
  import photon_cnt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_d;
  logic                   prev_q;

  // Shift the raw input into the chain and remember the last synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and previous-level flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/multi_ch_photon_binner.sv
// N-channel photon binner: counts synchronised photon edges per channel over
// bins of Tao clocks, snapshots each closed bin and streams it as N_CH words.
// A trigger edge force-closes the running bin and marks the next one; bins
// that close while the serialiser is still busy are dropped and counted.
module multi_ch_photon_binner
  import photon_cnt_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int TAO_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              TRIIN,
  input  logic [N_CH-1:0]   PHO,
  input  logic              write,
  input  logic [TAO_W-1:0]  Tao_Q,
  output logic [63:0]       Cnt_Stream,
  output logic              RDY,
  input  logic              ACK,
  output logic [15:0]       Drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Synchronised edge pulses.
  logic [N_CH-1:0] pho_rise;
  logic            trig_rise;

  // Bin timing.
  logic [TAO_W-1:0] tao_d, tao_q;
  logic [TAO_W-1:0] tao_pend_d, tao_pend_q;
  logic [TAO_W-1:0] timer_d, timer_q;
  logic [TAO_W-1:0] tao_eff;
  logic             nat_close;
  logic             bin_close;

  // Running counts and bin bookkeeping.
  logic [N_CH-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [N_CH-1:0][CNT_W-1:0] cnt_bumped;
  logic [N_CH-1:0]            sat_d, sat_q;
  logic [N_CH-1:0]            sat_bumped;
  logic [31:0]                seq_d, seq_q;
  logic                       trig_mark_d, trig_mark_q;
  logic [15:0]                drop_d, drop_q;

  // Snapshot of the bin being streamed.
  logic [N_CH-1:0][CNT_W-1:0] snap_cnt_d, snap_cnt_q;
  logic [N_CH-1:0]            snap_sat_d, snap_sat_q;
  logic [31:0]                snap_seq_d, snap_seq_q;
  logic                       snap_trig_d, snap_trig_q;

  // Serialiser.
  ser_state_e       state_d, state_q;
  logic [5:0]       ch_d, ch_q;
  logic             last_word;
  logic             ser_free;
  logic             snap_load;
  logic [CNT_W-1:0] sel_cnt;
  logic             sel_sat;

  for (genvar g = 0; g < N_CH; g++) begin : g_pho_sync
    pho_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_pho_sync (
      .clk        (CLK),
      .reset      (RESET),
      .async_in   (PHO[g]),
      .rise_pulse (pho_rise[g])
    );
  end

  pho_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk        (CLK),
    .reset      (RESET),
    .async_in   (TRIIN),
    .rise_pulse (trig_rise)
  );

  // Decide whether the running bin closes this cycle, naturally or by trigger.
  always_comb begin
    tao_eff   = (tao_q < TAO_W'(2)) ? TAO_W'(2) : tao_q;
    nat_close = (timer_q >= (tao_eff - TAO_W'(1)));
    bin_close = nat_close | trig_rise;
  end

  // Serialiser next state; a snapshot may load when idle or as the last word leaves.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    last_word = (ch_q == 6'(N_CH - 1));
    ser_free  = (state_q == SER_IDLE) || (ACK && last_word);
    snap_load = bin_close && ser_free;
    case (state_q)
      SER_IDLE: begin
        if (snap_load) begin
          state_d = SER_SEND;
          ch_d    = '0;
        end
      end
      SER_SEND: begin
        if (ACK) begin
          if (last_word) begin
            ch_d    = '0;
            state_d = snap_load ? SER_SEND : SER_IDLE;
          end else begin
            ch_d = ch_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = SER_IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // Count edges, close bins, take or drop snapshots and track the trigger mark.
  always_comb begin
    tao_pend_d  = write ? Tao_Q : tao_pend_q;
    tao_d       = tao_q;
    timer_d     = timer_q + TAO_W'(1);
    seq_d       = seq_q;
    trig_mark_d = trig_mark_q;
    drop_d      = drop_q;
    snap_cnt_d  = snap_cnt_q;
    snap_sat_d  = snap_sat_q;
    snap_seq_d  = snap_seq_q;
    snap_trig_d = snap_trig_q;
    cnt_bumped  = cnt_q;
    sat_bumped  = sat_q;
    for (int i = 0; i < N_CH; i++) begin
      if (pho_rise[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_bumped[i] = cnt_q[i] + CNT_W'(1);
      end
      sat_bumped[i] = sat_q[i] | (cnt_bumped[i] == CNT_MAX);
    end
    cnt_d = cnt_bumped;
    sat_d = sat_bumped;
    if (bin_close) begin
      tao_d   = tao_pend_q;
      timer_d = '0;
      cnt_d   = '0;
      sat_d   = '0;
      seq_d   = seq_q + 32'd1;
      if (snap_load) begin
        snap_cnt_d  = cnt_bumped;
        snap_sat_d  = sat_bumped;
        snap_seq_d  = seq_q;
        snap_trig_d = trig_mark_q;
        trig_mark_d = trig_rise;
      end else begin
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
        trig_mark_d = trig_mark_q | trig_rise;
      end
    end
  end

  // State registers; reset also abandons any word stream in progress.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tao_q       <= TAO_W'(TAO_RESET);
      tao_pend_q  <= TAO_W'(TAO_RESET);
      timer_q     <= '0;
      cnt_q       <= '0;
      sat_q       <= '0;
      seq_q       <= '0;
      trig_mark_q <= 1'b0;
      drop_q      <= '0;
      snap_cnt_q  <= '0;
      snap_sat_q  <= '0;
      snap_seq_q  <= '0;
      snap_trig_q <= 1'b0;
      state_q     <= SER_IDLE;
      ch_q        <= '0;
    end else begin
      tao_q       <= tao_d;
      tao_pend_q  <= tao_pend_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      seq_q       <= seq_d;
      trig_mark_q <= trig_mark_d;
      drop_q      <= drop_d;
      snap_cnt_q  <= snap_cnt_d;
      snap_sat_q  <= snap_sat_d;
      snap_seq_q  <= snap_seq_d;
      snap_trig_q <= snap_trig_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
    end
  end

  // Present the current channel's word while sending, zero otherwise.
  always_comb begin
    sel_cnt = '0;
    sel_sat = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == 6'(i)) begin
        sel_cnt = snap_cnt_q[i];
        sel_sat = snap_sat_q[i];
      end
    end
    Cnt_Stream = '0;
    if (state_q == SER_SEND) begin
      Cnt_Stream = pack_word(snap_trig_q, sel_sat, ch_q, 24'(sel_cnt), snap_seq_q);
    end
  end

  assign RDY      = (state_q == SER_SEND);
  assign Drop_cnt = drop_q;

endmodule

// File: tb/tb_multi_ch_photon_binner.sv
// Bench for multi_ch_photon_binner: two instances (wide and 4-bit counters)
// share random photon/trigger/ACK stimulus; an event-level model of bins,
// snapshots and drops predicts RDY, Cnt_Stream and Drop_cnt every cycle.
module tb_multi_ch_photon_binner;

  localparam int N_CH  = 4;
  localparam int TAO_W = 32;
  localparam int SYNC  = 2;
  localparam int MAXC  = 16384;
  localparam int MAX_W = 24'hFFFFFF;
  localparam int MAX_N = 15;

  typedef struct {
    int          ch;
    int unsigned seq;
    bit          trig;
    int          cnt;
  } word_t;

  logic             CLK;
  logic             RESET;
  logic             TRIIN;
  logic [N_CH-1:0]  PHO;
  logic             write;
  logic [TAO_W-1:0] Tao_Q;
  logic             ACK;
  logic [63:0]      stream_w, stream_n;
  logic             rdy_w, rdy_n;
  logic [15:0]      drop_w, drop_n;

  // Model state.
  word_t           exp_q[$];
  bit [N_CH-1:0]   pho_hist [0:MAXC];
  bit              trig_hist[0:MAXC];
  int              p;
  longint          m_pend;
  longint          m_next;
  int              m_cnt[N_CH];
  int unsigned     m_seq;
  bit              m_mark;
  int              m_drop;
  bit              chk_en;
  int              n_cmp;
  int              n_bad;

  multi_ch_photon_binner #(
    .N_CH(N_CH), .CNT_W(24), .TAO_W(TAO_W), .SYNC_STAGES(SYNC)
  ) dut_wide (
    .CLK(CLK), .RESET(RESET), .TRIIN(TRIIN), .PHO(PHO), .write(write),
    .Tao_Q(Tao_Q), .Cnt_Stream(stream_w), .RDY(rdy_w), .ACK(ACK), .Drop_cnt(drop_w)
  );

  multi_ch_photon_binner #(
    .N_CH(N_CH), .CNT_W(4), .TAO_W(TAO_W), .SYNC_STAGES(SYNC)
  ) dut_narrow (
    .CLK(CLK), .RESET(RESET), .TRIIN(TRIIN), .PHO(PHO), .write(write),
    .Tao_Q(Tao_Q), .Cnt_Stream(stream_n), .RDY(rdy_n), .ACK(ACK), .Drop_cnt(drop_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic longint eff(input longint t);
    return (t < 2) ? 64'sd2 : t;
  endfunction

  // Expected word for a counter that saturates at maxv.
  function automatic logic [63:0] mk(input word_t w, input int maxv);
    bit s;
    int c;
    s = (w.cnt >= maxv);
    c = s ? maxv : w.cnt;
    return {w.trig, s, 6'(w.ch), 24'(c), w.seq};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, p);
    end
  endtask

  // Compare every output of both instances with the model's view of this cycle.
  task automatic checkOutput();
    bit          exp_rdy;
    logic [63:0] ew, en;
    if (!chk_en) return;
    exp_rdy = (exp_q.size() != 0);
    ew = '0;
    en = '0;
    if (exp_rdy) begin
      ew = mk(exp_q[0], MAX_W);
      en = mk(exp_q[0], MAX_N);
    end
    chk("rdy_wide",    64'(rdy_w),  64'(exp_rdy));
    chk("rdy_narrow",  64'(rdy_n),  64'(exp_rdy));
    chk("word_wide",   stream_w,    ew);
    chk("word_narrow", stream_n,    en);
    chk("drop_wide",   64'(drop_w), 64'(m_drop));
    chk("drop_narrow", 64'(drop_n), 64'(m_drop));
  endtask

  // Advance the model by one clock edge using the inputs that edge sampled.
  task automatic model_step();
    bit [N_CH-1:0] e;
    bit            te;
    bit            close;
    bit            xfer;
    longint        old_pend;
    p++;
    pho_hist[p-1]  = PHO;
    trig_hist[p-1] = TRIIN;
    xfer = (exp_q.size() != 0) && ACK;
    if (RESET) begin
      m_pend = 65535;
      m_next = p + 65535;
      for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
      m_seq  = 0;
      m_mark = 1'b0;
      m_drop = 0;
      exp_q.delete();
      for (int k = 1; k <= SYNC + 3; k++) begin
        if (p - k >= 0) begin
          pho_hist[p-k]  = '0;
          trig_hist[p-k] = 1'b0;
        end
      end
      chk_en = 1'b1;
      return;
    end
    if (xfer) void'(exp_q.pop_front());
    e  = '0;
    te = 1'b0;
    if (p >= SYNC + 2) begin
      e  = pho_hist[p-(SYNC+1)] & ~pho_hist[p-(SYNC+2)];
      te = trig_hist[p-(SYNC+1)] & ~trig_hist[p-(SYNC+2)];
    end
    for (int i = 0; i < N_CH; i++) m_cnt[i] += int'(e[i]);
    close    = (longint'(p) == m_next) || te;
    old_pend = m_pend;
    if (write) m_pend = longint'(Tao_Q);
    if (close) begin
      if (exp_q.size() == 0) begin
        for (int i = 0; i < N_CH; i++) begin
          word_t w;
          w.ch   = i;
          w.seq  = m_seq;
          w.trig = m_mark;
          w.cnt  = m_cnt[i];
          exp_q.push_back(w);
        end
        m_mark = te;
      end else begin
        if (m_drop < 65535) m_drop++;
        m_mark = m_mark | te;
      end
      m_seq++;
      for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
      m_next = p + eff(old_pend);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    checkOutput();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  // Drive n cycles of random photon levels; density is the percent chance of high.
  task automatic applyStimulus(input int n, input int density);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N_CH; i++) PHO[i] = ($urandom_range(99) < density);
      tick();
    end
  endtask

  task automatic set_tao(input int t);
    Tao_Q = TAO_W'(t);
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic pulse_trig();
    TRIIN = 1'b1;
    tick();
    TRIIN = 1'b0;
  endtask

  initial begin
    bit found;
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    p      = 0;
    m_drop = 0;
    RESET  = 1'b1;
    TRIIN  = 1'b0;
    PHO    = '0;
    write  = 1'b0;
    Tao_Q  = '0;
    ACK    = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;

    // Reset-length bin must not close on its own within this window.
    applyStimulus(150, 50);

    // Program 100-cycle bins and align them with a trigger.
    $display("[TB] phase: 100-cycle bins");
    set_tao(100);
    pulse_trig();
    applyStimulus(400, 50);

    // Mid-bin trigger: short bin, then a marked bin, then an unmarked one.
    applyStimulus(37, 50);
    pulse_trig();
    applyStimulus(260, 50);

    // New length written mid-bin only applies after the running bin.
    applyStimulus(10, 50);
    set_tao(50);
    applyStimulus(260, 50);

    // Sparse photons keep the narrow counters below saturation.
    applyStimulus(200, 5);

    // Short bins with a stalled consumer overrun the serialiser.
    $display("[TB] phase: overrun");
    set_tao(6);
    applyStimulus(60, 30);
    ACK = 1'b0;
    applyStimulus(20, 30);
    ACK = 1'b1;
    applyStimulus(40, 30);

    // Random back-pressure with triggers sprinkled in.
    for (int c = 0; c < 200; c++) begin
      ACK = 1'($urandom_range(1));
      TRIIN = ($urandom_range(19) == 0);
      for (int i = 0; i < N_CH; i++) PHO[i] = ($urandom_range(99) < 40);
      tick();
    end
    ACK   = 1'b1;
    TRIIN = 1'b0;

    // Bins exactly N_CH long stream back-to-back; length 1 acts as 2.
    set_tao(4);
    applyStimulus(60, 30);
    set_tao(1);
    applyStimulus(30, 30);
    set_tao(40);
    applyStimulus(100, 40);

    // Reset while word 2 of a bin is on the stream.
    $display("[TB] phase: reset mid-stream");
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (exp_q.size() == 2) found = 1'b1;
      else applyStimulus(1, 40);
    end
    n_cmp++;
    assert (found) else begin
      n_bad++;
      $error("[TB] FAIL find_word2 observed=%0d expected=1", found);
    end
    PHO   = '0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    applyStimulus(200, 50);
    set_tao(30);
    pulse_trig();
    applyStimulus(120, 50);
    PHO = '0;
    applyStimulus(20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
